// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed seven-segment scanner: segment bit
// positions and the hex glyph table.
package seg7_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Glyphs for 0123456789AbCdEF, segment a in bit 0 through g in bit 6.
    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] hex_glyph(input logic [3:0] value);
        return HEX_GLYPH[value];
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to seven-segment glyph decoder.
module seg7_hex_decode (
    input  logic [3:0] value,
    output logic [6:0] seg
);
    import seg7_pkg::*;

    always_comb begin
        seg = hex_glyph(value);
    end

endmodule

// File: rtl/seg7_scan_n.sv
// Time-multiplexed N-digit seven-segment scanner with per-slot snapshot,
// brightness PWM window, blanking and selectable output polarity.
module seg7_scan_n #(
    parameter int DIGITS      = 4,
    parameter int PRESCALE    = 1000,
    parameter int BLANK       = 8,
    parameter int SEG_ACT_LOW = 0,
    parameter int SEL_ACT_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DIGITS*8-1:0]   data,
    input  logic                  hex_mode,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic [3:0]            bright,
    output logic [7:0]            segd,
    output logic [DIGITS-1:0]     sel,
    output logic                  frame_start
);
    import seg7_pkg::*;

    localparam int CW = $clog2(PRESCALE);
    localparam int IW = $clog2(DIGITS);
    localparam int OW = CW + 1;
    localparam int PW = CW + 5;
    localparam int RW = CW + 2;

    localparam logic [7:0]        SEG_OFF = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
    localparam logic [DIGITS-1:0] SEL_OFF = (SEL_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [RW-1:0]     LO      = RW'(BLANK);

    logic [CW-1:0]     cnt;
    logic [IW-1:0]     idx;
    logic [7:0]        snap_pat;
    logic              snap_blank;
    logic [OW-1:0]     snap_on;

    logic [7:0]        live_byte;
    logic              live_blank;
    logic [6:0]        hex_seg;
    logic [7:0]        live_pat;
    logic [PW-1:0]     prod;
    logic [OW-1:0]     live_on;
    logic              slot_start;
    logic [7:0]        cur_pat;
    logic              cur_blank;
    logic [OW-1:0]     cur_on;
    logic [RW-1:0]     rel;
    logic              lit;
    logic [DIGITS-1:0] sel_hot;

    seg7_hex_decode u_hex (
        .value (live_byte[3:0]),
        .seg   (hex_seg)
    );

    always_comb begin
        live_byte  = 8'h00;
        live_blank = 1'b0;
        sel_hot    = {DIGITS{1'b0}};
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IW'(k)) begin
                live_byte            = data[8*k +: 8];
                live_blank           = blank_mask[k];
                sel_hot[DIGITS-1-k] = 1'b1;
            end
        end
    end

    // At cnt=0 the live inputs feed the output directly while they are being
    // captured, so the first cycle of a slot already shows the new digit.
    always_comb begin
        live_pat   = hex_mode ? {live_byte[SEG_DP], hex_seg} : live_byte;
        prod       = PW'(PRESCALE - BLANK) * PW'({1'b0, bright} + 5'd1);
        live_on    = prod[PW-1:4];
        slot_start = (cnt == '0);
        cur_pat    = slot_start ? live_pat   : snap_pat;
        cur_blank  = slot_start ? live_blank : snap_blank;
        cur_on     = slot_start ? live_on    : snap_on;
        // Wraps to a huge value when cnt < BLANK, so one compare covers both bounds.
        rel        = {2'b00, cnt} - LO;
        lit        = en && !cur_blank && (rel < {1'b0, cur_on});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= '0;
            snap_pat   <= 8'h00;
            snap_blank <= 1'b0;
            snap_on    <= '0;
        end else if (en) begin
            if (cnt == CW'(PRESCALE - 1)) begin
                cnt <= '0;
                idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (slot_start) begin
                snap_pat   <= live_pat;
                snap_blank <= live_blank;
                snap_on    <= live_on;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            segd        <= SEG_OFF;
            sel         <= SEL_OFF;
            frame_start <= 1'b0;
        end else begin
            segd        <= (lit ? cur_pat : 8'h00) ^ SEG_OFF;
            sel         <= (lit ? sel_hot : {DIGITS{1'b0}}) ^ SEL_OFF;
            frame_start <= en && slot_start && (idx == '0);
        end
    end

endmodule

// File: tb/tb_seg7_scan_n.sv
// Scoreboard bench for seg7_scan_n: four instances cover raw/hex modes,
// brightness window, 3-digit wrap, mid-slot reset and inverted outputs.
module tb_seg7_scan_n;

    typedef struct {
        int         at;
        int         dut;
        logic [7:0] seg;
        logic [7:0] sel;
        logic       fs;
        int         sc;
        int         t;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] data;
    logic        hex_mode;
    logic [3:0]  mask;
    logic [3:0]  bright;

    logic [7:0] a_segd, b_segd, c_segd, d_segd;
    logic [3:0] a_sel, b_sel, d_sel;
    logic [2:0] c_sel;
    logic       a_fs, b_fs, c_fs, d_fs;

    int   cyc = 0;
    int   nvec = 0;
    int   nerr = 0;
    int   fs_count = 0;
    int   base;
    logic onehot_on = 1'b0;
    logic done = 1'b0;
    exp_t sb[$];
    exp_t cur_e;

    seg7_scan_n #(.DIGITS(4), .PRESCALE(16), .BLANK(0)) u_a (
        .clk(clk), .rst(rst), .en(en), .data(data), .hex_mode(hex_mode),
        .blank_mask(mask), .bright(bright), .segd(a_segd), .sel(a_sel), .frame_start(a_fs));

    seg7_scan_n #(.DIGITS(4), .PRESCALE(32), .BLANK(8)) u_b (
        .clk(clk), .rst(rst), .en(en), .data(data), .hex_mode(hex_mode),
        .blank_mask(mask), .bright(bright), .segd(b_segd), .sel(b_sel), .frame_start(b_fs));

    seg7_scan_n #(.DIGITS(3), .PRESCALE(16), .BLANK(0)) u_c (
        .clk(clk), .rst(rst), .en(en), .data(data[23:0]), .hex_mode(hex_mode),
        .blank_mask(mask[2:0]), .bright(bright), .segd(c_segd), .sel(c_sel), .frame_start(c_fs));

    seg7_scan_n #(.DIGITS(4), .PRESCALE(16), .BLANK(2), .SEG_ACT_LOW(1), .SEL_ACT_LOW(1)) u_d (
        .clk(clk), .rst(rst), .en(en), .data(data), .hex_mode(hex_mode),
        .blank_mask(mask), .bright(bright), .segd(d_segd), .sel(d_sel), .frame_start(d_fs));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic [31:0] d,
                                 input logic h, input logic [3:0] m, input logic [3:0] b);
        rst      = r;
        en       = e;
        data     = d;
        hex_mode = h;
        mask     = m;
        bright   = b;
    endtask

    task automatic pushExp(input int at, input int dut, input logic [7:0] s, input logic [7:0] l,
                           input logic f, input int sc, input int t);
        exp_t e;
        e.at  = at;
        e.dut = dut;
        e.seg = s;
        e.sel = l;
        e.fs  = f;
        e.sc  = sc;
        e.t   = t;
        sb.push_back(e);
    endtask

    // Expected outputs over len cycles from a slot boundary; lo..hi is the lit cnt range.
    task automatic frameExp(input int at0, input int dut, input int digits, input int pres,
                            input int lo, input int hi, input logic [31:0] bytes,
                            input logic [3:0] bmask, input int len, input logic actlow, input int sc);
        for (int t = 0; t < len; t++) begin
            int         k;
            int         j;
            logic       lt;
            logic [7:0] s;
            logic [7:0] l;
            j  = t % pres;
            k  = (t / pres) % digits;
            lt = !bmask[k] && (j >= lo) && (j <= hi);
            s  = lt ? bytes[8*k +: 8] : 8'h00;
            l  = lt ? (8'h01 << (digits - 1 - k)) : 8'h00;
            if (actlow) begin
                s = ~s;
                l = l ^ ((8'h01 << digits) - 8'h01);
            end
            pushExp(at0 + t, dut, s, l, (k == 0) && (j == 0), sc, t);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        logic [7:0] gs;
        logic [7:0] gl;
        logic       gf;
        case (e.dut)
            0:       begin gs = a_segd; gl = {4'b0, a_sel}; gf = a_fs; end
            1:       begin gs = b_segd; gl = {4'b0, b_sel}; gf = b_fs; end
            2:       begin gs = c_segd; gl = {5'b0, c_sel}; gf = c_fs; end
            default: begin gs = d_segd; gl = {4'b0, d_sel}; gf = d_fs; end
        endcase
        nvec++;
        if (e.at != cyc || gs !== e.seg || gl !== e.sel || gf !== e.fs) begin
            nerr++;
            $display("[TB] FAIL s%0d_t%0d (cyc %0d, due %0d): segd=%h sel=%h fs=%b, expected segd=%h sel=%h fs=%b",
                     e.sc, e.t, cyc, e.at, gs, gl, gf, e.seg, e.sel, e.fs);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            cur_e = sb.pop_front();
            checkOutput(cur_e);
        end
        if (onehot_on) begin
            nvec++;
            if ($countones(~d_sel) > 1) begin
                nerr++;
                $display("[TB] FAIL s6_onehot: active sel=%b, expected at most one bit", ~d_sel);
            end
        end
        if (done) begin
            nvec++;
            if (fs_count < 10) begin
                nerr++;
                $display("[TB] FAIL s6_frames: frame_start pulses=%0d, expected 10", fs_count);
            end
            nvec++;
            if (sb.size() != 0) begin
                nerr++;
                $display("[TB] FAIL sb_drain: %0d entries left, expected 0", sb.size());
            end
            $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
            $finish;
        end
    end

    initial begin
        // Scenario 1: raw bytes, full brightness, no blanking.
        applyStimulus(1'b1, 1'b0, 32'h11224488, 1'b0, 4'h0, 4'd15);
        pushExp(cyc + 1, 0, 8'h00, 8'h00, 1'b0, 1, -1);
        tick(1);
        applyStimulus(1'b0, 1'b1, 32'h11224488, 1'b0, 4'h0, 4'd15);
        base = cyc + 1;
        frameExp(base, 0, 4, 16, 0, 15, 32'h11224488, 4'h0, 65, 1'b0, 1);
        tick(66);

        // Scenario 2: BLANK=8, bright=3 gives on_len=6, lit at cnt 8..13.
        applyStimulus(1'b1, 1'b0, 32'h11224488, 1'b0, 4'h0, 4'd3);
        pushExp(cyc + 1, 1, 8'h00, 8'h00, 1'b0, 2, -1);
        tick(1);
        applyStimulus(1'b0, 1'b1, 32'h11224488, 1'b0, 4'h0, 4'd3);
        base = cyc + 1;
        frameExp(base, 1, 4, 32, 8, 13, 32'h11224488, 4'h0, 129, 1'b0, 2);
        tick(130);

        // Scenario 3: hex decode {D, C, 5, 8A}, digit 1 masked.
        applyStimulus(1'b1, 1'b0, 32'h0D0C058A, 1'b1, 4'b0010, 4'd15);
        pushExp(cyc + 1, 0, 8'h00, 8'h00, 1'b0, 3, -1);
        tick(1);
        applyStimulus(1'b0, 1'b1, 32'h0D0C058A, 1'b1, 4'b0010, 4'd15);
        base = cyc + 1;
        frameExp(base, 0, 4, 16, 0, 15, 32'h5E3900F7, 4'b0010, 65, 1'b0, 3);
        tick(66);

        // Scenario 4: three digits, digit 0 data changed mid-slot.
        applyStimulus(1'b1, 1'b0, 32'h00030201, 1'b0, 4'h0, 4'd15);
        pushExp(cyc + 1, 2, 8'h00, 8'h00, 1'b0, 4, -1);
        tick(1);
        applyStimulus(1'b0, 1'b1, 32'h00030201, 1'b0, 4'h0, 4'd15);
        base = cyc + 1;
        frameExp(base, 2, 3, 16, 0, 15, 32'h00030201, 4'h0, 48, 1'b0, 4);
        frameExp(base + 48, 2, 3, 16, 0, 15, 32'h000302F0, 4'h0, 49, 1'b0, 5);
        tick(6);
        applyStimulus(1'b0, 1'b1, 32'h000302F0, 1'b0, 4'h0, 4'd15);
        tick(92);

        // Scenario 5: reset at idx=2, cnt=7, restart at digit 0.
        applyStimulus(1'b1, 1'b0, 32'h11224488, 1'b0, 4'h0, 4'd15);
        pushExp(cyc + 1, 0, 8'h00, 8'h00, 1'b0, 6, -1);
        tick(1);
        applyStimulus(1'b0, 1'b1, 32'h11224488, 1'b0, 4'h0, 4'd15);
        base = cyc + 1;
        frameExp(base, 0, 4, 16, 0, 15, 32'h11224488, 4'h0, 39, 1'b0, 6);
        pushExp(base + 39, 0, 8'h00, 8'h00, 1'b0, 6, 39);
        frameExp(base + 40, 0, 4, 16, 0, 15, 32'h11224488, 4'h0, 17, 1'b0, 7);
        tick(39);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(18);

        // Scenario 6: inverted outputs, idle while disabled, then lit at cnt 2..8.
        applyStimulus(1'b1, 1'b0, 32'h11224488, 1'b0, 4'h0, 4'd7);
        for (int i = 1; i <= 4; i++) pushExp(cyc + i, 3, 8'hFF, 8'h0F, 1'b0, 8, -i);
        tick(1);
        applyStimulus(1'b0, 1'b0, 32'h11224488, 1'b0, 4'h0, 4'd7);
        tick(3);
        en = 1'b1;
        base = cyc + 1;
        frameExp(base, 3, 4, 16, 2, 8, 32'h11224488, 4'h0, 64, 1'b1, 9);
        tick(64);

        onehot_on = 1'b1;
        fs_count  = 0;
        for (int i = 0; i < 3000 && fs_count < 10; i++) begin
            en = 1'($urandom_range(0, 1));
            tick(1);
            if (d_fs) fs_count++;
        end
        onehot_on = 1'b0;
        done      = 1'b1;
        tick(4);
        $display("[TB] FAIL summary: monitor did not close the run");
        $fatal(1);
    end

endmodule

// File: doc/seg7_scan_n.md
SEG7_SCAN_N -- requirements
Module: seg7_scan_n

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, meaning the number of multiplexed digits (2..8).
REQ-002 The block SHALL have parameter PRESCALE, default 1000, meaning clk cycles per digit slot (>= 16).
REQ-003 The block SHALL have parameter BLANK, default 8, meaning dark cycles at the start of each slot (0 .. PRESCALE-16).
REQ-004 The block SHALL have parameter SEG_ACT_LOW, default 0, meaning segd is inverted when 1.
REQ-005 The block SHALL have parameter SEL_ACT_LOW, default 0, meaning sel is inverted when 1.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have port en, input, 1 bit: scan enable.
REQ-009 The block SHALL have port data, input, DIGITS*8 bits: digit k occupies bits [8k+7:8k].
REQ-010 The block SHALL have port hex_mode, input, 1 bit: 0 selects raw segment bytes, 1 selects hex decode of bits [3:0] with bit 7 as the decimal point.
REQ-011 The block SHALL have port blank_mask, input, DIGITS bits: when bit k is 1, digit k is never lit.
REQ-012 The block SHALL have port bright, input, 4 bits: duty level 0..15.
REQ-013 The block SHALL have port segd, output, 8 bits: segment drive, with bit 7 the decimal point.
REQ-014 The block SHALL have port sel, output, DIGITS bits: one-hot digit select, with digit k driving sel[DIGITS-1-k].
REQ-015 The block SHALL have port frame_start, output, 1 bit: a one-cycle pulse at the start of digit 0's slot.

Function
REQ-016 The block SHALL use slot counter cnt (0..PRESCALE-1) and digit index idx (0..DIGITS-1), with cnt incrementing on every clk cycle while en=1.
REQ-017 When cnt reaches PRESCALE-1, cnt SHALL return to 0 and idx SHALL increment, wrapping from DIGITS-1 to 0; no count is skipped or repeated for non-power-of-2 DIGITS.
REQ-018 While en=0, cnt and idx SHALL hold, and segd/sel SHALL be driven to inactive levels on the next cycle.
REQ-019 When cnt=0, the byte of the digit about to be shown (data, hex_mode, blank_mask bit) SHALL be snapshotted into a register; changes to these inputs mid-slot SHALL NOT affect the current slot.
REQ-020 on_len SHALL be computed as ((PRESCALE-BLANK)*(bright+1))>>4, with the product carried at full width with no truncation; bright SHALL be sampled at cnt=0.
REQ-021 The digit SHALL be lit only when BLANK <= cnt < BLANK+on_len and the snapshot blank bit is 0.
REQ-022 When the digit is lit, sel SHALL be the one-hot code for idx and segd SHALL be the snapshot pattern; otherwise sel and segd SHALL be all inactive.
REQ-023 segd and sel SHALL be registered outputs; the lit window defined by cnt SHALL appear on the outputs exactly 1 cycle later.
REQ-024 No two sel bits SHALL ever be simultaneously active, including across slot boundaries and enable toggles.
REQ-025 In hex decode, values 0-F SHALL map to the standard glyphs 0123456789AbCdEF, and segd[7] SHALL equal data bit 7.
REQ-026 frame_start SHALL be 1 for exactly one cycle, in the cycle after en=1, cnt=0 and idx=0, and 0 otherwise.
REQ-027 Polarity inversion SHALL be applied only at the output register, after all other logic.

Reset
REQ-028 On rst=1, on the next clk edge cnt SHALL be 0, idx SHALL be 0, the snapshot SHALL be 0, segd SHALL be inactive (8'h00, or 8'hFF if SEG_ACT_LOW), sel SHALL be inactive, and frame_start SHALL be 0.
REQ-029 rst SHALL override en, and assertion of rst mid-slot SHALL abandon the slot, with scanning restarting at digit 0, cnt 0.

Structure
REQ-030 Package seg7_pkg SHALL hold the 16-entry hex glyph constant table and the segment bit-order constants.
REQ-031 The block SHALL contain one combinational sub-module, seg7_hex_decode, which takes a 4-bit value and returns 7 segments.
REQ-032 There SHALL be no other sub-modules, and the block SHALL have no clock gating or derived clocks.

Verification
REQ-033 Scenario 1: DIGITS=4, PRESCALE=16, BLANK=0, bright=15, raw data {8'h11,8'h22,8'h44,8'h88} -> sel sequence 8,4,2,1, each held for 16 cycles, with segd=8'h88, 8'h44, 8'h22, 8'h11 in turn.
REQ-034 Scenario 2: PRESCALE=32, BLANK=8, bright=3 -> on_len=6, with each digit lit at cnt 8..13 (outputs at 9..14) and dark for the rest of the slot.
REQ-035 Scenario 3: hex_mode=1, digit 0 = 8'h8A -> segd shows 'A' glyph with bit 7 = 1, and blank_mask=4'b0010 -> digit 1 slot is dark throughout.
REQ-036 Scenario 4: DIGITS=3 -> idx sequence 0,1,2,0, with frame_start pulsing every 3*PRESCALE cycles, and a data change at cnt=5 not visible until the next slot of that digit.
REQ-037 Scenario 5: rst asserted at idx=2, cnt=7 -> outputs inactive on the next cycle, and after release the first lit digit is digit 0 with frame_start=1.
REQ-038 Scenario 6: SEG_ACT_LOW=1, SEL_ACT_LOW=1, en=0 -> segd=8'hFF and sel all 1s, and a one-hot assertion checker passes over 10 full frames with random en toggling.
